// File: rtl/l2_chan_fifo_bank.sv
// Bank of independent first-word-fall-through valid/ready FIFOs, one per L2 message channel,
// with per-channel output hold, bank-wide flush, occupancy and sticky high-watermark.
module l2_chan_fifo_bank #(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [NUM_CH-1:0]       out_valid,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  input  logic [NUM_CH-1:0]       out_ready,
  input  logic [NUM_CH-1:0]       hold,
  input  logic                    flush,
  input  logic                    wm_clr,
  output logic [NUM_CH*CW-1:0]    occupancy,
  output logic [NUM_CH*CW-1:0]    watermark
);

  localparam int unsigned PW = $clog2(DEPTH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    wm_q, wm_d;
    logic             push, pop;

    // in_ready depends on registered count only, never on out_ready.
    assign in_ready[i]  = (count_q != CW'(DEPTH));
    assign out_valid[i] = (count_q != '0) && !hold[i];
    assign push         = in_valid[i] && in_ready[i];
    assign pop          = out_valid[i] && out_ready[i];

    assign out_data[i*WIDTH +: WIDTH] = mem_q[head_q];
    assign occupancy[i*CW +: CW]      = count_q;
    assign watermark[i*CW +: CW]      = wm_q;

    always_comb begin
      count_d = count_q;
      if (flush) begin
        count_d = '0;
      end else if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end

    // wm_clr keeps the post-edge level; combined with flush that level is zero.
    always_comb begin
      wm_d = wm_q;
      if (wm_clr) begin
        wm_d = count_d;
      end else if (count_d > wm_q) begin
        wm_d = count_d;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        wm_q    <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          mem_q[k] <= '0;
        end
      end else begin
        count_q <= count_d;
        wm_q    <= wm_d;
        if (flush) begin
          head_q <= '0;
          tail_q <= '0;
        end else begin
          if (push) begin
            mem_q[tail_q] <= in_data[i*WIDTH +: WIDTH];
            tail_q        <= tail_q + PW'(1);
          end
          if (pop) begin
            head_q <= head_q + PW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_chan_fifo_bank.sv
// Directed bench for l2_chan_fifo_bank: stimulus queues expected words per channel,
// a negedge monitor checks every output handshake against those queues.
module tb_l2_chan_fifo_bank;

  localparam int unsigned NUM_CH = 5;
  localparam int unsigned WIDTH  = 64;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CW     = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic [NUM_CH-1:0]       out_ready;
  logic [NUM_CH-1:0]       hold;
  logic                    flush;
  logic                    wm_clr;
  logic [NUM_CH*CW-1:0]    occupancy;
  logic [NUM_CH*CW-1:0]    watermark;

  logic [WIDTH-1:0] exp_q [NUM_CH][$];
  int n_total = 0;
  int n_pass  = 0;

  l2_chan_fifo_bank #(
    .NUM_CH(NUM_CH),
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .hold     (hold),
    .flush    (flush),
    .wm_clr   (wm_clr),
    .occupancy(occupancy),
    .watermark(watermark)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] occ(input int c);
    return occupancy[c*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] wm(input int c);
    return watermark[c*CW +: CW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int c, input logic [WIDTH-1:0] v);
    in_data[c*WIDTH +: WIDTH] = v;
  endtask

  // Drive a word that the bench knows will be accepted at the next edge.
  task automatic push_word(input int c, input logic [WIDTH-1:0] v);
    in_valid[c] = 1'b1;
    set_data(c, v);
    exp_q[c].push_back(v);
  endtask

  task automatic clear_exp();
    for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
  endtask

  // Monitor: every accepted pop must match the oldest outstanding word on that channel.
  always @(negedge clk) begin
    if (rst === 1'b1 && flush === 1'b0) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (out_valid[c] && out_ready[c]) begin
          if (exp_q[c].size() == 0) begin
            n_total++;
            $display("FAIL pop_ch%0d: got %0h expected no pop", c, out_data[c*WIDTH +: WIDTH]);
          end else begin
            chk($sformatf("pop_ch%0d", c), out_data[c*WIDTH +: WIDTH], exp_q[c].pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst       = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '0;
    hold      = '0;
    flush     = 1'b0;
    wm_clr    = 1'b0;

    // Reset state, checked while reset is still asserted.
    #12;
    chk("rst_in_ready", WIDTH'(in_ready), WIDTH'(5'h1f));
    chk("rst_out_valid", WIDTH'(out_valid), '0);
    chk("rst_occupancy", WIDTH'(occupancy), '0);
    chk("rst_watermark", WIDTH'(watermark), '0);
    chk("rst_out_data", WIDTH'(out_data[WIDTH-1:0]), '0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("idle_in_ready", WIDTH'(in_ready), WIDTH'(5'h1f));

    // Ch0: fill to DEPTH, then try a push while full with a pop in the same cycle.
    push_word(0, 64'h11); step();
    push_word(0, 64'h22); step();
    push_word(0, 64'h33); step();
    push_word(0, 64'h44); step();
    in_valid[0] = 1'b0;
    chk("ch0_full_in_ready", WIDTH'(in_ready[0]), '0);
    chk("ch0_full_occ", WIDTH'(occ(0)), 64'd4);
    chk("ch0_full_wm", WIDTH'(wm(0)), 64'd4);
    chk("ch0_full_out_valid", WIDTH'(out_valid[0]), 64'd1);
    in_valid[0]  = 1'b1;
    set_data(0, 64'h55);
    out_ready[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    chk("ch0_fullpop_occ", WIDTH'(occ(0)), 64'd3);
    chk("ch0_fullpop_in_ready", WIDTH'(in_ready[0]), 64'd1);
    step(); step(); step();
    out_ready[0] = 1'b0;
    chk("ch0_drain_occ", WIDTH'(occ(0)), '0);
    chk("ch0_drain_out_valid", WIDTH'(out_valid[0]), '0);

    // Ch2: hold at two entries with simultaneous push/pop so pointers wrap several times.
    push_word(2, 64'h200); step();
    push_word(2, 64'h201); step();
    out_ready[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push_word(2, 64'h202 + 64'(k));
      step();
      chk($sformatf("ch2_pushpop_occ_%0d", k), WIDTH'(occ(2)), 64'd2);
    end
    in_valid[2] = 1'b0;
    step(); step();
    out_ready[2] = 1'b0;
    chk("ch2_drain_occ", WIDTH'(occ(2)), '0);

    // Ch1: hold blocks pops but not pushes; releasing it shows the original head.
    hold[1]      = 1'b1;
    out_ready[1] = 1'b1;
    push_word(1, 64'hb0); step();
    push_word(1, 64'hb1); step();
    push_word(1, 64'hb2); step();
    in_valid[1] = 1'b0;
    step(); step();
    chk("ch1_hold_out_valid", WIDTH'(out_valid[1]), '0);
    chk("ch1_hold_occ", WIDTH'(occ(1)), 64'd3);
    hold[1] = 1'b0;
    #1;
    chk("ch1_release_out_valid", WIDTH'(out_valid[1]), 64'd1);
    chk("ch1_release_head", out_data[1*WIDTH +: WIDTH], 64'hb0);
    step(); step(); step();
    out_ready[1] = 1'b0;
    chk("ch1_drain_occ", WIDTH'(occ(1)), '0);

    // Ch3: flush beats a concurrent push; watermark survives.
    push_word(3, 64'hc0); step();
    push_word(3, 64'hc1); step();
    flush = 1'b1;
    set_data(3, 64'hc2);
    exp_q[3].delete();
    step();
    flush       = 1'b0;
    in_valid[3] = 1'b0;
    chk("ch3_flush_occ", WIDTH'(occ(3)), '0);
    chk("ch3_flush_out_valid", WIDTH'(out_valid[3]), '0);
    chk("ch3_flush_wm", WIDTH'(wm(3)), 64'd2);
    chk("ch3_flush_in_ready", WIDTH'(in_ready[3]), 64'd1);

    // Ch4: wm_clr keeps the current level; wm_clr with flush zeroes everything.
    push_word(4, 64'hd0); step();
    push_word(4, 64'hd1); step();
    push_word(4, 64'hd2); step();
    push_word(4, 64'hd3); step();
    in_valid[4] = 1'b0;
    chk("ch4_full_wm", WIDTH'(wm(4)), 64'd4);
    chk("ch4_full_in_ready", WIDTH'(in_ready[4]), '0);
    out_ready[4] = 1'b1;
    step(); step(); step();
    out_ready[4] = 1'b0;
    chk("ch4_occ_1", WIDTH'(occ(4)), 64'd1);
    chk("ch4_wm_sticky", WIDTH'(wm(4)), 64'd4);
    chk("ch1_wm_sticky", WIDTH'(wm(1)), 64'd3);
    wm_clr = 1'b1;
    step();
    wm_clr = 1'b0;
    chk("ch4_wmclr", WIDTH'(wm(4)), 64'd1);
    chk("ch1_wmclr", WIDTH'(wm(1)), '0);
    wm_clr = 1'b1;
    flush  = 1'b1;
    clear_exp();
    step();
    wm_clr = 1'b0;
    flush  = 1'b0;
    chk("wmclr_flush_wm", WIDTH'(watermark), '0);
    chk("wmclr_flush_occ", WIDTH'(occupancy), '0);

    // Asynchronous reset in the middle of a burst on ch0.
    push_word(0, 64'h71); step();
    push_word(0, 64'h72); step();
    set_data(0, 64'h73);
    chk("burst_occ", WIDTH'(occ(0)), 64'd2);
    #2;
    rst = 1'b0;
    clear_exp();
    #1;
    chk("async_rst_in_ready", WIDTH'(in_ready), WIDTH'(5'h1f));
    chk("async_rst_out_valid", WIDTH'(out_valid), '0);
    chk("async_rst_occ", WIDTH'(occupancy), '0);
    chk("async_rst_wm", WIDTH'(watermark), '0);
    in_valid = '0;
    step();
    rst = 1'b1;
    step();
    chk("post_rst_occ", WIDTH'(occupancy), '0);
    chk("post_rst_out_valid", WIDTH'(out_valid), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/l2_chan_fifo_bank.md
Name: l2_chan_fifo_bank

Overview:
- Parametrised bank of NUM_CH independent valid/ready FIFOs between the L2 message channels (cpu_req, fwd_in, rsp_in, req_out, rsp_out, ...) and the NoC or test harness.
- Generalises the single fixed handshake per channel of the L2 top to configurable width, depth and channel count.
- Adds per-channel hold (back-pressure injection), synchronous flush, live occupancy and a sticky high-watermark for stats and verification.

Parameters:
- NUM_CH, 5, number of independent channels (1..16).
- WIDTH, 64, payload bits per channel, carrying a packed message struct.
- DEPTH, 4, entries per channel FIFO; power of two, at least 2.
- CW, $clog2(DEPTH+1), derived width of the occupancy and watermark fields; not to be overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  NUM_CH  per-channel producer valid.
- in_data  in  NUM_CH*WIDTH  payloads; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  NUM_CH  per-channel FIFO can accept.
- out_valid  out  NUM_CH  per-channel head entry available.
- out_data  out  NUM_CH*WIDTH  head payloads, same packing as in_data.
- out_ready  in  NUM_CH  per-channel consumer ready.
- hold  in  NUM_CH  per-channel output stall.
- flush  in  1  synchronous clear of all channel contents.
- wm_clr  in  1  clear all high-watermarks.
- occupancy  out  NUM_CH*CW  per-channel entry count.
- watermark  out  NUM_CH*CW  per-channel max occupancy since last clear.

Behaviour:
- Reset (rst=0, asynchronous): all pointers, counts and watermarks go to 0. in_ready=all 1, out_valid=0, occupancy=0, watermark=0. out_data is don't-care but must be X-free: storage resets to 0.
- Channels are fully independent. No arbitration and no cross-channel ordering.
- Push: in_valid[i] && in_ready[i] at a clock edge writes the payload at the tail and advances the tail.
- Pop: out_valid[i] && out_ready[i] advances the head.
- in_ready[i] = (count_i != DEPTH). It is registered-state only, with no combinational path from out_ready.
- out_valid[i] = (count_i != 0) && !hold[i]. out_data shows the head entry combinationally from storage (first-word fall-through). out_data is stable while out_valid=1 and no pop occurs.
- Latency: a word pushed at edge N is visible on out_valid/out_data after edge N. There is no same-cycle bypass when empty.
- Simultaneous push and pop on the same channel: count unchanged and both pointers advance. This is legal whenever count is between 1 and DEPTH-1.
- Full channel: in_ready=0, so no push even if a pop occurs that cycle. The pop frees a slot and in_ready rises next cycle.
- Empty channel: out_valid=0 and out_ready is ignored.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is CW bits and never exceeds DEPTH.
- hold[i]=1 masks out_valid[i] and blocks pops. Pushes continue and data is retained. Deasserting hold exposes the same head word.
- flush=1: at the next edge all heads, tails and counts are zeroed; pushes and pops that cycle are discarded. Flush has priority over push and pop. Watermarks are unaffected by flush.
- watermark_i updates to count_next_i whenever count_next_i > watermark_i.
- wm_clr=1 loads watermark_i <= count_next_i, so the current level is kept rather than dropped to 0. If wm_clr and flush are both high, watermark becomes 0.
- occupancy_i = count_i, registered.
- Reset asserted mid-operation drops all in-flight contents immediately. There is no drain.
- Invariants for the verification engineer: never push when !in_ready; never pop when !out_valid; per-channel output order equals input order.

Test Plan:
- Reset then idle: in_ready=5'b11111, out_valid=0, occupancy and watermark all 0.
- Ch0 pushes 0x11, 0x22, 0x33, 0x44 with out_ready=0 → in_ready[0]=0 after the 4th edge, occupancy0=4, watermark0=4. Then out_ready=1 → outputs 0x11..0x44 in order, one per cycle.
- Ch2 at count 2 with simultaneous push/pop for 10 cycles → occupancy2 stays 2, output sequence intact, pointers wrap correctly.
- Ch1 holding 3 entries with hold[1]=1 and out_ready=1 → out_valid[1]=0 and occupancy1 stays 3. Release hold → head word shown unchanged.
- flush asserted with ch3 at 2 entries and a push on ch3 that cycle → occupancy3=0 next cycle, out_valid[3]=0, watermark3 still 2.
- wm_clr with ch4 at count 1 and watermark4=4 → watermark4=1. Reset asserted mid-burst → all outputs return to reset values asynchronously.
